cache_way_sel_ctrl: RTL and testbench

//  Clocked controller that sequences the 4-way cache selector, one request at a time.
//  Per request it picks the target way: the hit way, else the lowest invalid way, else the tree-PLRU victim.
//  It drives the selector's valid0..3 and i_drive, tracks fire/free completion and updates per-set PLRU state.

---
 rtl/cache_way_sel_ctrl_pkg.sv | 44 ++++
 rtl/cache_way_sel_ctrl_if.sv | 39 +++
 rtl/cache_way_sel_ctrl_plru_tree4.sv | 25 ++
 rtl/cache_way_sel_ctrl.sv | 144 ++++++++++++++
 tb/tb_cache_way_sel_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_way_sel_ctrl_pkg.sv
// Shared types for the 4-way cache selector controller: FSM states, way index
// width, per-set tree-PLRU bit layout and small way-selection helpers.
package cache_way_sel_ctrl_pkg;

  localparam int unsigned WAY_W    = 2;
  localparam int unsigned NUM_WAYS = 4;

  typedef logic [WAY_W-1:0] way_t;

  // Tree-PLRU bits of one set: b0 = root, b1 = left pair (ways 0/1),
  // b2 = right pair (ways 2/3).
  typedef struct packed {
    logic b0;
    logic b1;
    logic b2;
  } plru_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT_FIRE,
    S_WAIT_DONE,
    S_UPDATE
  } state_t;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input way_t w);
    way_onehot    = '0;
    way_onehot[w] = 1'b1;
  endfunction

  // Lowest-index way whose valid bit is clear; 0 when all ways are valid.
  function automatic way_t first_invalid(input logic [NUM_WAYS-1:0] valid);
    logic found;
    found         = 1'b0;
    first_invalid = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (!valid[i] && !found) begin
        first_invalid = way_t'(i);
        found         = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/cache_way_sel_ctrl_if.sv
// Request / selector / completion signal bundle of cache_way_sel_ctrl.
//   master : lookup stage + selector feedback (drives req_*, way_valid,
//            sel_fire, sel_done; observes everything else)
//   slave  : the controller itself
interface cache_way_sel_ctrl_if #(
  parameter int unsigned SET_W = 4
);
  import cache_way_sel_ctrl_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [SET_W-1:0] req_set;
  logic             req_hit;
  way_t             req_hit_way;
  logic [3:0]       way_valid;
  logic [3:0]       sel_valid;
  logic             sel_drive;
  logic             sel_fire;
  logic             sel_done;
  logic             grant_valid;
  way_t             grant_way;
  logic             timeout_err;
  logic             busy;

  modport master (
    output req_valid, req_set, req_hit, req_hit_way, way_valid,
    output sel_fire, sel_done,
    input  req_ready, sel_valid, sel_drive, grant_valid, grant_way,
    input  timeout_err, busy
  );

  modport slave (
    input  req_valid, req_set, req_hit, req_hit_way, way_valid,
    input  sel_fire, sel_done,
    output req_ready, sel_valid, sel_drive, grant_valid, grant_way,
    output timeout_err, busy
  );

endinterface

// File: rtl/cache_way_sel_ctrl_plru_tree4.sv
// Combinational 4-way tree-PLRU helper.
//   state      : current PLRU bits of a set
//   way        : accessed way
//   victim     : least-recently-used way according to state
//   next_state : PLRU bits after an access to way
module plru_tree4
  import cache_way_sel_ctrl_pkg::*;
(
  input  plru_t state,
  input  way_t  way,
  output way_t  victim,
  output plru_t next_state
);

  always_comb begin
    if (!state.b0) victim = state.b1 ? way_t'(1) : way_t'(0);
    else           victim = state.b2 ? way_t'(3) : way_t'(2);

    next_state    = state;
    next_state.b0 = ~way[1];
    if (!way[1]) next_state.b1 = (way == way_t'(0));
    else         next_state.b2 = (way == way_t'(2));
  end

endmodule

// File: rtl/cache_way_sel_ctrl.sv
// Sequences the 4-way cache selector one request at a time: picks the target
// way (hit way, else lowest invalid way, else tree-PLRU victim), drives the
// selector valids and i_drive pulse, waits for fire then done, and updates
// the per-set PLRU on completion. Aborts with timeout_err if the selector
// stalls.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request handshake, selector drive/feedback, grant/timeout
module cache_way_sel_ctrl
  import cache_way_sel_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 16,
  parameter int unsigned SET_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_way_sel_ctrl_if.slave  bus
);

  // One extra count value so the counter can step past the limit when a fire
  // edge lands exactly on it; the following WAIT_DONE cycle then still aborts.
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  plru_t            plru [NUM_SETS];
  logic [SET_W-1:0] set_r;
  logic [SET_W-1:0] acc_set;
  way_t             way_r;
  way_t             pick_way;
  way_t             victim;
  plru_t            tree_state;
  plru_t            tree_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_limit;
  logic             fire_prev;
  logic             fire_rise;
  logic [3:0]       sel_valid_q;
  logic             sel_drive_q;
  logic             grant_valid_q;
  way_t             grant_way_q;
  logic             timeout_err_q;

  always_comb begin
    acc_set = (32'(bus.req_set) < NUM_SETS) ? bus.req_set : '0;
  end

  // One PLRU tree serves both uses: victim lookup for the incoming set while
  // idle, next-state computation for the registered set during UPDATE.
  always_comb begin
    tree_state = (state == S_IDLE) ? plru[acc_set] : plru[set_r];
  end

  plru_tree4 u_plru (
    .state      (tree_state),
    .way        (way_r),
    .victim     (victim),
    .next_state (tree_next)
  );

  always_comb begin
    if (bus.req_hit)          pick_way = bus.req_hit_way;
    else if (~&bus.way_valid) pick_way = first_invalid(bus.way_valid);
    else                      pick_way = victim;
  end

  always_comb begin
    fire_rise = bus.sel_fire & ~fire_prev;
    cnt_limit = (cnt >= CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      set_r         <= '0;
      way_r         <= '0;
      cnt           <= '0;
      fire_prev     <= 1'b0;
      sel_valid_q   <= '0;
      sel_drive_q   <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_way_q   <= '0;
      timeout_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SETS; i++) plru[i] <= '0;
    end else begin
      fire_prev     <= bus.sel_fire;
      sel_drive_q   <= 1'b0;
      grant_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            set_r       <= acc_set;
            way_r       <= pick_way;
            sel_valid_q <= way_onehot(pick_way);
            sel_drive_q <= 1'b1;
            state       <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          cnt   <= '0;
          state <= S_WAIT_FIRE;
        end
        S_WAIT_FIRE: begin
          cnt <= cnt + 1'b1;
          if (fire_rise) begin
            state <= S_WAIT_DONE;
          end else if (cnt_limit) begin
            timeout_err_q <= 1'b1;
            sel_valid_q   <= '0;
            state         <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (bus.sel_done) begin
            grant_valid_q <= 1'b1;
            grant_way_q   <= way_r;
            state         <= S_UPDATE;
          end else if (cnt_limit) begin
            timeout_err_q <= 1'b1;
            sel_valid_q   <= '0;
            state         <= S_IDLE;
          end
        end
        S_UPDATE: begin
          plru[set_r] <= tree_next;
          sel_valid_q <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.sel_valid   = sel_valid_q;
  assign bus.sel_drive   = sel_drive_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_way   = grant_way_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cache_way_sel_ctrl.sv
// Self-checking bench for cache_way_sel_ctrl with a behavioural PLRU /
// way-choice reference model and cycle-accurate expectations per request.
module tb_cache_way_sel_ctrl;

  localparam int unsigned NSETS = 16;
  localparam int unsigned SW    = 4;
  localparam int unsigned TO    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_way_sel_ctrl_if #(.SET_W(SW)) bus ();

  cache_way_sel_ctrl #(
    .NUM_SETS    (NSETS),
    .SET_W       (SW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference PLRU state per set.
  bit m_b0 [NSETS];
  bit m_b1 [NSETS];
  bit m_b2 [NSETS];

  // Continuous-request phase bookkeeping.
  int acc = 0, drives = 0, completions = 0, ph = 0;
  bit respond = 1'b0;
  int q_way [$];
  int g, exp_acc, t, k;

  function automatic int victim(input int s);
    if (!m_b0[s]) return m_b1[s] ? 1 : 0;
    return m_b2[s] ? 3 : 2;
  endfunction

  function automatic void touch(input int s, input int w);
    m_b0[s] = (w < 2);
    if (w < 2) m_b1[s] = (w == 0);
    else       m_b2[s] = (w == 2);
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < NSETS; i++) begin
      m_b0[i] = 0; m_b1[i] = 0; m_b2[i] = 0;
    end
  endfunction

  function automatic int pick(input int s, input bit hit, input int hw, input logic [3:0] wv);
    if (hit) return hw;
    for (int i = 0; i < 4; i++) if (!wv[i]) return i;
    return victim(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request. fire_at / done edge are cycle offsets from the accept edge.
  task automatic do_req(input int s, input bit hit, input int hw, input logic [3:0] wv,
                        input int fire_at, input int done_after, input bit early,
                        output int got);
    int w, lim, fd, to_c, end_c;
    bit ok;
    logic [3:0] oh;
    w     = pick(s, hit, hw, wv);
    lim   = TO + 1;               // TO cycles after entering WAIT_FIRE
    fd    = fire_at + done_after;
    to_c  = (fire_at == lim) ? lim + 1 : lim;
    ok    = (fire_at <= lim) && (fd <= to_c);
    end_c = ok ? fd + 1 : to_c;
    oh    = 4'(1 << w);
    got   = -1;
    check("ready_idle", bus.req_ready, 1);
    bus.req_set     = SW'(s);
    bus.req_hit     = hit;
    bus.req_hit_way = 2'(hw);
    bus.way_valid   = wv;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("drive_pulse", bus.sel_drive, 1);
    check("valid_at_drive", bus.sel_valid, oh);
    check("ready_busy", bus.req_ready, 0);
    for (int c = 1; c <= end_c; c++) begin
      bus.sel_fire = (c >= fire_at);
      bus.sel_done = (c >= fd) || (early && c == fire_at);
      tick();
      check("grant_valid", bus.grant_valid, ok && c == fd);
      check("timeout_err", bus.timeout_err, !ok && c == end_c);
      check("drive_low", bus.sel_drive, 0);
      check("sel_valid", bus.sel_valid, (c < end_c) ? oh : 4'h0);
      check("busy", bus.busy, c < end_c);
      check("ready", bus.req_ready, c >= end_c);
      if (bus.grant_valid) got = int'(bus.grant_way);
      if (ok && c == fd) check("grant_way", bus.grant_way, w);
    end
    bus.sel_fire = 1'b0;
    bus.sel_done = 1'b0;
    if (ok) touch(s, w);
  endtask

  // Reactive selector for the back-to-back phase: every third request stalls.
  task automatic obs_cont();
    int w;
    if (bus.sel_drive) begin
      drives++;
      ph      = 1;
      respond = (acc % 3) != 0;
    end else if (ph > 0) begin
      ph++;
    end
    if (bus.grant_valid || bus.timeout_err) begin
      check("cont_q_nonempty", 32'(q_way.size() > 0), 1);
      if (q_way.size() > 0) begin
        w = q_way.pop_front();
        if (bus.grant_valid) begin
          check("cont_grant_way", bus.grant_way, w);
          touch(9, w);
        end
      end
      completions++;
    end
    bus.sel_fire = respond && (ph == 2);
    bus.sel_done = respond && (ph == 3);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_set = '0; bus.req_hit = 0; bus.req_hit_way = '0;
    bus.way_valid = '0; bus.sel_fire = 0; bus.sel_done = 0;
    clear_model();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_sel_valid", bus.sel_valid, 0);
    check("rst_drive", bus.sel_drive, 0);
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_grant_way", bus.grant_way, 0);
    check("rst_timeout", bus.timeout_err, 0);

    // Full misses on set 3: PLRU sequence from reset.
    do_req(3, 0, 0, 4'hF, 2, 1, 0, g); check("seq0", g, 0);
    do_req(3, 0, 0, 4'hF, 2, 1, 0, g); check("seq1", g, 2);
    do_req(3, 0, 0, 4'hF, 2, 1, 0, g); check("seq2", g, 1);
    do_req(3, 0, 0, 4'hF, 2, 1, 0, g); check("seq3", g, 3);

    // Invalid-way choice counts as a PLRU access.
    do_req(5, 0, 0, 4'hF,    2, 1, 0, g); check("s5_a", g, 0);
    do_req(5, 0, 0, 4'b1011, 2, 1, 0, g); check("s5_inv", g, 2);
    do_req(5, 0, 0, 4'hF,    2, 1, 0, g); check("s5_after", g, 1);

    // Hit way overrides invalid ways and updates PLRU.
    do_req(7, 0, 0, 4'hF, 2, 1, 0, g); check("s7_a", g, 0);
    do_req(7, 0, 0, 4'hF, 2, 1, 0, g); check("s7_b", g, 2);
    do_req(7, 1, 3, 4'h0, 2, 1, 0, g); check("s7_hit", g, 3);
    do_req(7, 0, 0, 4'hF, 2, 1, 0, g); check("s7_c", g, 1);
    do_req(7, 0, 0, 4'hF, 2, 1, 0, g); check("s7_d", g, 2);

    // Timeout leaves PLRU untouched.
    do_req(3, 0, 0, 4'hF, 2, 1, 0, g);   check("s3_pre_to", g, 0);
    do_req(3, 0, 0, 4'hF, 100, 1, 0, g);
    do_req(3, 0, 0, 4'hF, 2, 1, 0, g);   check("s3_post_to", g, 2);

    // Boundaries: done on the last count, fire on the last count, late done,
    // done coincident with the fire edge.
    do_req(11, 0, 0, 4'hF, 2, 7, 0, g);
    do_req(11, 0, 0, 4'hF, 9, 1, 0, g);
    do_req(11, 0, 0, 4'hF, 9, 2, 0, g);
    do_req(11, 0, 0, 4'hF, 3, 7, 0, g);
    do_req(11, 0, 0, 4'hF, 2, 3, 1, g);

    // Reset while waiting for done.
    bus.req_set = SW'(3); bus.req_hit = 0; bus.way_valid = 4'hF; bus.req_valid = 1;
    tick();
    bus.req_valid = 0;
    tick();
    bus.sel_fire = 1;
    tick();
    rst = 1'b1;
    bus.sel_fire = 0;
    tick();
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sel_valid", bus.sel_valid, 0);
    check("mid_rst_drive", bus.sel_drive, 0);
    check("mid_rst_grant_valid", bus.grant_valid, 0);
    check("mid_rst_grant_way", bus.grant_way, 0);
    check("mid_rst_timeout", bus.timeout_err, 0);
    rst = 1'b0;
    clear_model();
    tick();
    do_req(3, 0, 0, 4'hF, 2, 1, 0, g); check("s3_cleared", g, 0);
    do_req(5, 0, 0, 4'hF, 2, 1, 0, g); check("s5_cleared", g, 0);

    // req_valid held high: one accept per completed or aborted request.
    bus.req_set = SW'(9); bus.req_hit = 0; bus.way_valid = 4'hF; bus.req_valid = 1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (bus.req_ready) begin
        acc++;
        q_way.push_back(victim(9));
      end
      tick();
      obs_cont();
    end
    bus.req_valid = 0;
    for (int i = 0; i < 30 && bus.busy; i++) begin
      tick();
      obs_cont();
    end
    tick();
    obs_cont();
    bus.sel_fire = 0; bus.sel_done = 0;
    // Answered requests occupy 5 cycles, stalled ones TO+2.
    exp_acc = 0; t = 0; k = 1;
    while (t < 100) begin
      exp_acc++;
      t += ((k % 3) != 0) ? 5 : int'(TO) + 2;
      k++;
    end
    check("cont_accepts", acc, exp_acc);
    check("cont_drives", drives, acc);
    check("cont_completions", completions, acc);
    check("cont_drained", bus.busy, 0);
    check("cont_queue_empty", q_way.size(), 0);

    // Randomised requests against the model.
    for (int n = 0; n < 40; n++) begin
      int rs, rhw, rfa, rda;
      bit rh, re;
      logic [3:0] rwv;
      rs  = int'($urandom_range(0, NSETS - 1));
      rh  = ($urandom_range(0, 3) == 0);
      rhw = int'($urandom_range(0, 3));
      rwv = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      rfa = int'($urandom_range(2, 11));
      rda = int'($urandom_range(1, 5));
      re  = $urandom_range(0, 1) == 1;
      do_req(rs, rh, rhw, rwv, rfa, rda, re, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
